// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (see program_loader.sv).
package loader_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StFlush,
        StRun,
        StError
    } loader_state_e;

    localparam int unsigned LOADER_DATA_W = 32;
    localparam int unsigned RELEASE_PC    = 0;

endpackage

// File: rtl/program_loader_if.sv
// Host-to-loader program word stream (valid/ready with a last marker).
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = loader_pkg::LOADER_DATA_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/loader_checksum.sv
// Running 32-bit modular sum of the program words streamed into the loader.
module loader_checksum
    import loader_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     add_en_i,
    input  logic [LOADER_DATA_W-1:0] word_i,
    output logic [LOADER_DATA_W-1:0] sum_o
);

    logic [LOADER_DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (add_en_i) begin
            sum_d = sum_q + word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Holds the core in reset while streaming program words into instruction memory, then releases it.
// Define LOADER_CHECKSUM_EN to treat the in_last beat as a checksum word over the program.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = LOADER_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  restart_i,
    program_loader_if.slave       in_if,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_wdata_o,
    output logic                  cpu_reset_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(RELEASE_PC);
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = '1;

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;

    logic accept;
    logic write_en;
    logic sum_ok;
    logic restart_take;

    assign in_if.in_ready = (state_q == StLoad);
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign restart_take   = restart_i & ((state_q == StRun) | (state_q == StError));

`ifdef LOADER_CHECKSUM_EN
    logic [LOADER_DATA_W-1:0] sum_word;
    logic [LOADER_DATA_W-1:0] sum;

    assign sum_word = LOADER_DATA_W'(in_if.in_data);
    // The last beat carries the checksum and is never written to memory.
    assign write_en = accept & ~in_if.in_last;
    assign sum_ok   = (sum == sum_word);

    loader_checksum u_checksum (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (restart_take),
        .add_en_i (write_en),
        .word_i   (sum_word),
        .sum_o    (sum)
    );
`else
    assign write_en = accept;
    assign sum_ok   = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (write_en) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wr_ptr_q;
            imem_wdata_d = in_if.in_data;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
        end

        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (in_if.in_last) begin
                        state_d = sum_ok ? StFlush : StError;
                    end else if (wr_ptr_q == LastAddr) begin
                        // Memory is full and the stream did not end: the word is still written.
                        state_d = StError;
                    end
                end
            end
            StFlush: begin
                state_d = StRun;
            end
            StRun, StError: begin
                if (restart_take) begin
                    state_d      = StLoad;
                    wr_ptr_d     = StartAddr;
                    word_count_d = '0;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StLoad;
            wr_ptr_q     <= StartAddr;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    // The core leaves reset only once FLUSH has retired the final write.
    assign cpu_reset_o  = (state_q != StRun);
    assign done_o       = (state_q == StRun);
    assign error_o      = (state_q == StError);
    assign word_count_o = word_count_q;

endmodule
